// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port memory_controller between NUM_REQ requesters.
// One transaction in flight; completion is the fall of mc_grant, answered by a one-cycle resp_valid.
module mem_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          mc_req,
    output logic                          mc_we,
    output logic [ADDR_WIDTH-1:0]         mc_addr,
    output logic [DATA_WIDTH-1:0]         mc_wdata,
    input  logic [DATA_WIDTH-1:0]         mc_rdata,
    input  logic                          mc_grant,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ID_WIDTH-1:0]     r_ptr;
    logic [ID_WIDTH-1:0]     r_owner;
    logic                    r_busy;
    logic                    r_mc_req;
    logic                    r_mc_we;
    logic [ADDR_WIDTH-1:0]   r_mc_addr;
    logic [DATA_WIDTH-1:0]   r_mc_wdata;
    logic [NUM_REQ-1:0]      r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;

    state_t                  w_state_nxt;
    logic [ID_WIDTH-1:0]     w_ptr_nxt;
    logic [ID_WIDTH-1:0]     w_owner_nxt;
    logic                    w_mc_req_nxt;
    logic                    w_mc_we_nxt;
    logic [ADDR_WIDTH-1:0]   w_mc_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_mc_wdata_nxt;
    logic [NUM_REQ-1:0]      w_resp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_resp_rdata_nxt;

    logic [ADDR_WIDTH-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_wdata_arr [NUM_REQ];
    logic [ID_WIDTH-1:0]     w_idx;
    logic [ID_WIDTH-1:0]     w_winner;
    logic                    w_any;
    logic [NUM_REQ-1:0]      w_win_onehot;

    // Unpack the flat per-requester payload buses.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search from r_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_WIDTH'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << w_winner;
    assign req_ready    = (r_state == ST_IDLE && w_any) ? w_win_onehot : '0;

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_owner_nxt      = r_owner;
        w_mc_req_nxt     = r_mc_req;
        w_mc_we_nxt      = r_mc_we;
        w_mc_addr_nxt    = r_mc_addr;
        w_mc_wdata_nxt   = r_mc_wdata;
        w_resp_valid_nxt = '0;
        w_resp_rdata_nxt = r_resp_rdata;
        case (r_state)
            ST_IDLE: begin
                // mc_grant is deliberately ignored here so a stale grant cannot complete anything.
                if (w_any) begin
                    w_state_nxt    = ST_ISSUE;
                    w_owner_nxt    = w_winner;
                    w_mc_req_nxt   = 1'b1;
                    w_mc_we_nxt    = req_we[w_winner];
                    w_mc_addr_nxt  = w_addr_arr[w_winner];
                    w_mc_wdata_nxt = w_wdata_arr[w_winner];
                    w_ptr_nxt      = (w_winner == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                          : w_winner + ID_WIDTH'(1);
                end
            end
            ST_ISSUE: begin
                if (mc_grant) begin
                    w_mc_req_nxt = 1'b0;
                    w_state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mc_grant) begin
                    w_resp_valid_nxt = NUM_REQ'(1) << r_owner;
                    if (!r_mc_we) begin
                        w_resp_rdata_nxt = mc_rdata;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mc_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_busy       <= 1'b0;
            r_mc_req     <= 1'b0;
            r_mc_we      <= 1'b0;
            r_mc_addr    <= '0;
            r_mc_wdata   <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_owner      <= w_owner_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_mc_req     <= w_mc_req_nxt;
            r_mc_we      <= w_mc_we_nxt;
            r_mc_addr    <= w_mc_addr_nxt;
            r_mc_wdata   <= w_mc_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mc_req     = r_mc_req;
    assign mc_we      = r_mc_we;
    assign mc_addr    = r_mc_addr;
    assign mc_wdata   = r_mc_wdata;
    assign busy       = r_busy;
    assign owner      = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory_controller (BURST_LEN=4) plus a transaction-level
// round-robin model; directed scenarios followed by randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned NR    = 2;
    localparam int unsigned IW    = 1;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int          BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid, req_ready, req_we, resp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    resp_rdata, mc_wdata, mc_rdata;
    logic [AW-1:0]    mc_addr;
    logic             mc_req, mc_we, mc_grant, busy;
    logic [IW-1:0]    owner;

    logic             mem_ready;
    logic [15:0]      mem_hi;
    int               beats;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               m_ptr;
    logic [DW-1:0]    m_rdata;

    typedef struct {
        logic [NR-1:0] ready;
        logic [NR-1:0] ready_after;
        int            wait_cyc;
        logic          mc_req0;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [IW-1:0] own;
        logic          busy0;
        logic          resp0;
        int            lat;
        int            busy_low;
        int            req_bad;
        logic [NR-1:0] resp;
        logic [DW-1:0] rdata;
        bit            timeout;
    } obs_t;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata), .mc_grant(mc_grant),
        .busy(busy), .owner(owner)
    );

    // Controller: grant on sampled mc_req, BURST beats gated by mem_ready, read beat k = {mem_hi, k}.
    always @(posedge clk) begin
        if (!rst_n) begin
            mc_grant <= 1'b0;
            beats    <= 0;
            mc_rdata <= '0;
        end else if (!mc_grant) begin
            if (mc_req) begin
                mc_grant <= 1'b1;
                beats    <= 0;
            end
        end else if (mem_ready) begin
            if (!mc_we) mc_rdata <= {mem_hi, 16'(beats)};
            if (beats == BURST - 1) mc_grant <= 1'b0;
            else beats <= beats + 1;
        end
    end

    function automatic int model_winner(input logic [NR-1:0] v, input int p);
        int order[$];
        for (int k = 0; k < int'(NR); k++) order.push_back((p + k) % int'(NR));
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_rdata = '0;
    endtask

    // Drives one transaction to completion and records what the DUT showed; called at a negedge.
    task automatic run_txn(input int stall, input bit keep, output obs_t o);
        o = '{default: 0};
        #1;
        while (req_ready == '0) begin
            if (o.wait_cyc >= 20) begin o.timeout = 1'b1; return; end
            @(negedge clk); #1;
            o.wait_cyc++;
        end
        o.ready = req_ready;
        @(posedge clk);
        @(negedge clk);
        o.ready_after = req_ready;
        o.mc_req0 = mc_req;
        o.we      = mc_we;
        o.addr    = mc_addr;
        o.wdata   = mc_wdata;
        o.own     = owner;
        o.busy0   = busy;
        o.resp0   = |resp_valid;
        if (!keep) req_valid = req_valid & ~o.ready;
        while (resp_valid == '0) begin
            if (o.lat >= 2 && mc_req) o.req_bad++;
            if (!busy) o.busy_low++;
            if (stall > 0 && o.lat == 3) mem_ready = 1'b0;
            if (o.lat == 3 + stall) mem_ready = 1'b1;
            if (o.lat >= 60) begin o.timeout = 1'b1; mem_ready = 1'b1; return; end
            @(negedge clk);
            o.lat++;
        end
        o.resp  = resp_valid;
        o.rdata = resp_rdata;
    endtask

    task automatic test_reset();
        logic [AW+2*DW+NR+NR+IW+3-1:0] got;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_rdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            got = {mc_req, busy, mc_we, owner, resp_valid, req_ready, mc_addr, mc_wdata, resp_rdata};
            n_checks++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%h required all zero", c, got);
            end
        end
    endtask

    task automatic test_single_read();
        obs_t o;
        mem_hi = 16'hA5A5;
        set_req(1, 1'b0, 32'h100, 32'h0);
        run_txn(0, 1'b0, o);
        n_checks++;
        if (o.timeout) begin n_fail++; $display("FAIL read_timeout: no accept/response"); return; end
        n_checks++;
        if ({o.ready, o.ready_after} !== {2'b10, 2'b00}) begin
            n_fail++; $display("FAIL read_ready: got %b then %b, required 10 then 00", o.ready, o.ready_after);
        end
        n_checks++;
        if ({o.mc_req0, o.we, o.addr, o.own, o.busy0} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL read_issue: mc_req=%b we=%b addr=%h owner=%0d busy=%b required 1 0 100 1 1",
                     o.mc_req0, o.we, o.addr, o.own, o.busy0);
        end
        n_checks++;
        if (o.lat !== 6) begin n_fail++; $display("FAIL read_latency: got %0d required 6", o.lat); end
        n_checks++;
        if ({o.resp, o.rdata} !== {2'b10, 32'hA5A5_0003}) begin
            n_fail++; $display("FAIL read_resp: valid=%b rdata=%h required 10 a5a50003", o.resp, o.rdata);
        end
        m_ptr   = 0;
        m_rdata = 32'hA5A5_0003;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL read_pulse_width: resp_valid=%b required 00", resp_valid); end
    endtask

    task automatic test_single_write();
        obs_t o;
        set_req(0, 1'b1, 32'h200, 32'hDEAD_BEEF);
        run_txn(0, 1'b0, o);
        n_checks++;
        if (o.timeout) begin n_fail++; $display("FAIL write_timeout: no accept/response"); return; end
        n_checks++;
        if ({o.ready, o.we, o.addr, o.wdata, o.own} !== {2'b01, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL write_issue: ready=%b we=%b addr=%h wdata=%h owner=%0d required 01 1 200 deadbeef 0",
                     o.ready, o.we, o.addr, o.wdata, o.own);
        end
        n_checks++;
        if ({o.resp, o.rdata, o.lat} !== {2'b01, m_rdata, 6}) begin
            n_fail++;
            $display("FAIL write_resp: valid=%b rdata=%h lat=%0d required 01 %h 6", o.resp, o.rdata, o.lat, m_rdata);
        end
        m_ptr = 1;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL write_pulse_width: resp_valid=%b required 00", resp_valid); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   order [4] = '{0, 1, 0, 1};
        apply_reset();
        set_req(0, 1'b0, 32'h1000, 32'h0);
        set_req(1, 1'b0, 32'h2000, 32'h0);
        for (int j = 0; j < 4; j++) begin
            mem_hi = 16'(j + 16'h0B00);
            run_txn(0, j < 2, o);
            n_checks++;
            if (o.timeout) begin n_fail++; $display("FAIL rr_timeout txn %0d", j); return; end
            n_checks++;
            if ({o.ready, o.own, o.resp} !== {onehot(order[j]), IW'(order[j]), onehot(order[j])}) begin
                n_fail++;
                $display("FAIL rr_order txn %0d: ready=%b owner=%0d resp=%b required winner %0d",
                         j, o.ready, o.own, o.resp, order[j]);
            end
            n_checks++;
            if ({o.addr, o.rdata} !== {(order[j] == 0) ? 32'h1000 : 32'h2000, mem_hi, 16'h0003}) begin
                n_fail++; $display("FAIL rr_data txn %0d: addr=%h rdata=%h", j, o.addr, o.rdata);
            end
            n_checks++;
            if (o.wait_cyc != 0 || o.req_bad != 0 || o.resp0 !== 1'b0 || o.lat != 6) begin
                n_fail++;
                $display("FAIL rr_flow txn %0d: wait=%0d extra_mc_req=%0d prev_resp_stuck=%b lat=%0d required 0 0 0 6",
                         j, o.wait_cyc, o.req_bad, o.resp0, o.lat);
            end
            m_ptr   = (order[j] + 1) % int'(NR);
            m_rdata = {mem_hi, 16'h0003};
        end
    endtask

    task automatic test_stall();
        obs_t o;
        mem_hi = 16'($urandom);
        set_req(0, 1'b0, 32'h300, 32'h0);
        run_txn(5, 1'b0, o);
        n_checks++;
        if (o.timeout) begin n_fail++; $display("FAIL stall_timeout"); return; end
        n_checks++;
        if (o.lat != 11 || o.req_bad != 0 || o.busy_low != 0) begin
            n_fail++;
            $display("FAIL stall_wait: lat=%0d mc_req_in_wait=%0d busy_low=%0d required 11 0 0",
                     o.lat, o.req_bad, o.busy_low);
        end
        n_checks++;
        if ({o.resp, o.rdata} !== {2'b01, mem_hi, 16'h0003}) begin
            n_fail++; $display("FAIL stall_resp: valid=%b rdata=%h required 01 %h0003", o.resp, o.rdata, mem_hi);
        end
        m_ptr   = 1;
        m_rdata = {mem_hi, 16'h0003};
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL stall_pulse_width: resp_valid=%b", resp_valid); end
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        int   t = 0;
        logic seen;
        m_ptr = 0;
        set_req(0, 1'b0, 32'h400, 32'h0);
        #1;
        while (req_ready == '0 && t < 20) begin @(negedge clk); #1; t++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || mc_req !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_pre: busy=%b mc_req=%b required 1 0", busy, mc_req);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_rdata = '0;
        n_checks++;
        if ({busy, mc_req, resp_valid, owner, mc_addr} !== '0) begin
            n_fail++;
            $display("FAIL rstwait_state: busy=%b mc_req=%b resp=%b owner=%0d addr=%h required zeros",
                     busy, mc_req, resp_valid, owner, mc_addr);
        end
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen |= (|resp_valid) | mc_req; end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rstwait_abandon: late resp_valid/mc_req=%b required 0", seen); end
        mem_hi = 16'h5A5A;
        set_req(0, 1'b1, 32'h500, 32'h1234_5678);
        set_req(1, 1'b0, 32'h600, 32'h0);
        run_txn(0, 1'b0, o);
        n_checks++;
        if (o.timeout || o.ready !== 2'b01 || o.resp !== 2'b01) begin
            n_fail++; $display("FAIL rstwait_ptr: ready=%b resp=%b required 01 01 (pointer back at 0)", o.ready, o.resp);
        end
        run_txn(0, 1'b0, o);
        n_checks++;
        if (o.timeout || {o.ready, o.resp, o.rdata, o.lat} !== {2'b10, 2'b10, 32'h5A5A_0003, 6}) begin
            n_fail++;
            $display("FAIL rstwait_fresh: ready=%b resp=%b rdata=%h lat=%0d required 10 10 5a5a0003 6",
                     o.ready, o.resp, o.rdata, o.lat);
        end
        m_ptr   = 0;
        m_rdata = 32'h5A5A_0003;
    endtask

    task automatic test_random();
        obs_t          o;
        int            exp_w, stall;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rdata;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < int'(NR); i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            if (req_valid == '0)
                set_req(int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            mem_hi  = 16'($urandom);
            stall   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
            exp_w   = model_winner(req_valid, m_ptr);
            e_we    = req_we[exp_w];
            e_addr  = req_addr[exp_w*AW +: AW];
            e_wdata = req_wdata[exp_w*DW +: DW];
            e_rdata = e_we ? m_rdata : {mem_hi, 16'h0003};
            run_txn(stall, 1'b0, o);
            n_checks++;
            if (o.timeout) begin n_fail++; $display("FAIL rand_timeout iter %0d", it); return; end
            n_checks++;
            if ({o.ready, o.own, o.resp} !== {onehot(exp_w), IW'(exp_w), onehot(exp_w)}) begin
                n_fail++;
                $display("FAIL rand_grant iter %0d: ready=%b owner=%0d resp=%b required winner %0d",
                         it, o.ready, o.own, o.resp, exp_w);
            end
            n_checks++;
            if ({o.we, o.addr, o.wdata} !== {e_we, e_addr, e_wdata}) begin
                n_fail++;
                $display("FAIL rand_payload iter %0d: we=%b addr=%h wdata=%h required %b %h %h",
                         it, o.we, o.addr, o.wdata, e_we, e_addr, e_wdata);
            end
            n_checks++;
            if (o.rdata !== e_rdata || o.lat != 6 + stall || o.req_bad != 0 || o.resp0 !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_resp iter %0d: rdata=%h lat=%0d extra_req=%0d stuck=%b required %h %0d 0 0",
                         it, o.rdata, o.lat, o.req_bad, o.resp0, e_rdata, 6 + stall);
            end
            m_ptr   = (exp_w + 1) % int'(NR);
            m_rdata = e_rdata;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b1;
        mem_hi    = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
